// File: rtl/result_dump_engine.sv
// Streams the cpu result region (RESULT_BASE..RESULT_BASE+RESULT_WORDS-1) out over valid/ready once the run ends.
// Optional DUMP_CHECKSUM_EN appends a modulo-2**DATA_W sum beat (out_addr=0) after the last data word.
module result_dump_engine #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 12,
   parameter int RESULT_BASE   = 2048,
   parameter int RESULT_WORDS  = 1024,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              complete,
   input  logic              error,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              run_error
);

   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RESULT_BASE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RESULT_BASE + RESULT_WORDS - 1);
   localparam int                CNT_W     = $clog2(SETTLE_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_ISSUE, S_CAPTURE, S_SEND, S_DONE
   } state_t;

   state_t             state_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [CNT_W-1:0]   settle_cnt_reg;
   logic               mem_rd_en_reg;
   logic [ADDR_W-1:0]  mem_addr_reg;
   logic               out_valid_reg;
   logic [ADDR_W-1:0]  out_addr_reg;
   logic [DATA_W-1:0]  out_data_reg;
   logic               out_last_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               run_error_reg;
   logic               handshake;
   logic [ADDR_W-1:0]  addr_next;

   assign handshake = out_valid_reg & out_ready;
   assign addr_next = addr_reg + ADDR_W'(1);

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0]  sum_reg;
   logic [DATA_W-1:0]  sum_next;
   logic               csum_phase_reg;

   assign sum_next = sum_reg + out_data_reg;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         addr_reg       <= BASE_ADDR;
         settle_cnt_reg <= '0;
         mem_rd_en_reg  <= 1'b0;
         mem_addr_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_addr_reg   <= '0;
         out_data_reg   <= '0;
         out_last_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         run_error_reg  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         sum_reg        <= '0;
         csum_phase_reg <= 1'b0;
`endif
      end else begin
         // The read strobe is a single-cycle pulse raised on entry to ISSUE.
         mem_rd_en_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (complete | error) begin
                  run_error_reg  <= error;
                  busy_reg       <= 1'b1;
                  addr_reg       <= BASE_ADDR;
                  settle_cnt_reg <= '0;
`ifdef DUMP_CHECKSUM_EN
                  sum_reg        <= '0;
                  csum_phase_reg <= 1'b0;
`endif
                  if (SETTLE_CYCLES > 0) begin
                     state_reg <= S_SETTLE;
                  end else begin
                     state_reg     <= S_ISSUE;
                     mem_rd_en_reg <= 1'b1;
                     mem_addr_reg  <= BASE_ADDR;
                  end
               end
            end
            S_SETTLE: begin
               if (settle_cnt_reg == SETTLE_END) begin
                  state_reg     <= S_ISSUE;
                  mem_rd_en_reg <= 1'b1;
                  mem_addr_reg  <= addr_reg;
               end else begin
                  settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
               end
            end
            S_ISSUE: begin
               state_reg <= S_CAPTURE;
            end
            S_CAPTURE: begin
               out_data_reg  <= mem_rdata;
               out_addr_reg  <= addr_reg;
               out_valid_reg <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
               out_last_reg  <= 1'b0;
`else
               out_last_reg  <= (addr_reg == LAST_ADDR);
`endif
               state_reg     <= S_SEND;
            end
            S_SEND: begin
               if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
                  if (csum_phase_reg) begin
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
                     state_reg     <= S_DONE;
                  end else if (addr_reg == LAST_ADDR) begin
                     // Checksum beat follows back-to-back; no memory read needed.
                     sum_reg        <= sum_next;
                     out_addr_reg   <= '0;
                     out_data_reg   <= sum_next;
                     out_last_reg   <= 1'b1;
                     csum_phase_reg <= 1'b1;
                  end else begin
                     sum_reg       <= sum_next;
                     out_valid_reg <= 1'b0;
                     addr_reg      <= addr_next;
                     mem_rd_en_reg <= 1'b1;
                     mem_addr_reg  <= addr_next;
                     state_reg     <= S_ISSUE;
                  end
`else
                  out_valid_reg <= 1'b0;
                  if (out_last_reg) begin
                     out_last_reg <= 1'b0;
                     busy_reg     <= 1'b0;
                     done_reg     <= 1'b1;
                     state_reg    <= S_DONE;
                  end else begin
                     addr_reg      <= addr_next;
                     mem_rd_en_reg <= 1'b1;
                     mem_addr_reg  <= addr_next;
                     state_reg     <= S_ISSUE;
                  end
`endif
               end
            end
            S_DONE: begin
               state_reg <= S_DONE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_rd_en = mem_rd_en_reg;
   assign mem_addr  = mem_addr_reg;
   assign out_valid = out_valid_reg;
   assign out_addr  = out_addr_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign run_error = run_error_reg;

endmodule

// File: tb/tb_result_dump_engine.sv
// Randomized bench for result_dump_engine: a queue of expected beats is built from the memory image, then matched against the stream.
module tb_result_dump_engine;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int BASE   = 2048;
   localparam int WORDS  = 4;
   localparam int SETTLE = 1;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              l;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              complete;
   logic              error;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              run_error;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   beat_t             exp_q[$];
   int                total = 0;
   int                bad   = 0;

   result_dump_engine #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESULT_BASE(BASE),
      .RESULT_WORDS(WORDS), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .reset(reset), .complete(complete), .error(error),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .run_error(run_error)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data appears one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; complete = 1'b0; error = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic build_expected();
      logic [DATA_W-1:0] sum;
      beat_t b;
      sum = '0;
      exp_q.delete();
      for (int i = 0; i < WORDS; i++) begin
         sum = sum + mem[BASE + i];
         b.a = ADDR_W'(BASE + i);
         b.d = mem[BASE + i];
`ifdef DUMP_CHECKSUM_EN
         b.l = 1'b0;
`else
         b.l = (i == WORDS - 1);
`endif
         exp_q.push_back(b);
      end
`ifdef DUMP_CHECKSUM_EN
      b.a = '0; b.d = sum; b.l = 1'b1;
      exp_q.push_back(b);
`endif
   endtask

   // Runs one dump from IDLE; abort_addr != 0 asserts reset while that word is offered.
   task automatic run_dump(input string name, input logic c, input logic e, input int ready_pct,
                           input int stall_addr, input int abort_addr);
      int    edges, first, got, reads, stall_left, exp_n;
      logic  stalled, aborted;
      logic [44:0] prev;
      beat_t b;
      build_expected();
      exp_n = exp_q.size();
      complete = c; error = e; out_ready = 1'b0;
      tick();
      complete = 1'b0; error = 1'b0;
      check_eq({name, ":busy"}, 64'(busy), 64'd1);
      edges = 0; first = -1; got = 0; reads = 0; stall_left = 5;
      stalled = 1'b0; aborted = 1'b0; prev = '0;
      while (got < exp_n && edges < 600) begin
         if (mem_rd_en) reads++;
         if (out_valid && first < 0) first = edges;
         if (stalled) check_eq({name, ":stable"}, 64'({out_addr, out_data, out_last}), 64'(prev));
         if (out_valid && abort_addr != 0 && int'(out_addr) == abort_addr) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_eq({name, ":rst_outs"},
                     64'({mem_rd_en, mem_addr, out_valid, out_addr, out_last, busy, done, run_error}), 64'd0);
            check_eq({name, ":rst_data"}, 64'(out_data), 64'd0);
            aborted = 1'b1;
            break;
         end
         if (out_valid && int'(out_addr) == stall_addr && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < ready_pct);
         end
         if (out_valid && out_ready) begin
            b = exp_q.pop_front();
            check_eq({name, ":addr"}, 64'(out_addr), 64'(b.a));
            check_eq({name, ":data"}, 64'(out_data), 64'(b.d));
            check_eq({name, ":last"}, 64'(out_last), 64'(b.l));
            $display("beat %s addr=%0d data=0x%08h last=%0b", name, out_addr, out_data, out_last);
            got++;
         end
         stalled = out_valid && !out_ready;
         prev = {out_addr, out_data, out_last};
         tick();
         edges++;
      end
      out_ready = 1'b0;
      if (!aborted) begin
         check_eq({name, ":beats"}, 64'(got), 64'(exp_n));
         check_eq({name, ":latency"}, 64'(first), 64'(SETTLE + 2));
         check_eq({name, ":reads"}, 64'(reads), 64'(WORDS));
         check_eq({name, ":done"}, 64'(done), 64'd1);
         check_eq({name, ":busy_end"}, 64'(busy), 64'd0);
         check_eq({name, ":valid_end"}, 64'(out_valid), 64'd0);
         check_eq({name, ":run_error"}, 64'(run_error), 64'(e));
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < WORDS; i++) mem[BASE + i] = $urandom;
   endtask

   initial begin
      int reads;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      mem_rdata = '0;
      do_reset();
      check_eq("reset_outs",
               64'({mem_rd_en, mem_addr, out_valid, out_addr, out_last, busy, done, run_error}), 64'd0);
      check_eq("reset_data", 64'(out_data), 64'd0);

      // Basic dump with signed values and a free-running consumer.
      mem[BASE + 0] = 32'd5;
      mem[BASE + 1] = 32'hFFFF_FFFD;
      mem[BASE + 2] = 32'd0;
      mem[BASE + 3] = 32'd7;
      run_dump("basic", 1'b1, 1'b0, 100, 0, 0);

      // Reset while word 2050 is on offer, then a fresh dump with backpressure at 2049.
      do_reset();
      run_dump("abort", 1'b1, 1'b0, 100, 0, BASE + 2);
      fill_random();
      run_dump("restart", 1'b1, 1'b0, 100, BASE + 1, 0);

      // Error-only and both-high triggers, with random backpressure.
      do_reset();
      fill_random();
      run_dump("err", 1'b0, 1'b1, 60, BASE + 1, 0);
      do_reset();
      fill_random();
      run_dump("both", 1'b1, 1'b1, 40, 0, 0);

      // Held complete plus a later error pulse must not restart the dump.
      reads = 0;
      complete = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (mem_rd_en) reads++;
      end
      complete = 1'b0; error = 1'b1;
      tick();
      error = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (mem_rd_en) reads++;
         tick();
      end
      check_eq("retrig_reads", 64'(reads), 64'd0);
      check_eq("retrig_done", 64'(done), 64'd1);
      check_eq("retrig_valid", 64'(out_valid), 64'd0);

      // Values whose sum wraps past 32 bits.
      do_reset();
      mem[BASE + 0] = 32'hFFFF_FFFF;
      mem[BASE + 1] = 32'h8000_0000;
      mem[BASE + 2] = 32'h8000_0000;
      mem[BASE + 3] = 32'h0000_0003;
      run_dump("wrap", 1'b1, 1'b0, 75, 0, 0);

      // A few fully random runs.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         fill_random();
         run_dump("rand", 1'($urandom_range(1)), 1'b1, 30 + 20 * r, BASE + r % WORDS, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/result_dump_engine.md
Name: result_dump_engine

Overview:
Hardware stage directly downstream of the cpu. When the cpu raises complete or error, it scans the result region of the unified memory (addresses 2048..3071) through a read port and streams each word out on a valid/ready interface. A host or bridge consumes the stream. This makes the end-of-run result dump available in hardware as well as in simulation.

Parameters:
DATA_W, 32, memory word width in bits
ADDR_W, 12, memory address width
RESULT_BASE, 2048, first address dumped
RESULT_WORDS, 1024, number of words dumped (>=1)
SETTLE_CYCLES, 1, cycles waited after trigger before the first read (>=0)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
complete  in  1  cpu finished normally (level)
error  in  1  cpu halted on error (level)
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  stream word valid
out_ready  in  1  consumer accepts word
out_addr  out  ADDR_W  memory address of out_data
out_data  out  DATA_W  result word, raw bits (consumer treats as signed)
out_last  out  1  marks final beat of the dump
busy  out  1  dump in progress
done  out  1  dump finished; sticky until reset
run_error  out  1  latched error status of the run

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE. All outputs 0. Internal address=RESULT_BASE. Settle counter=0. Reset overrides every other event, including mid-dump or mid-handshake; no beat is completed on that edge.
- Trigger: in IDLE, the first clk edge where (complete|error)=1. On that edge:
  - run_error <= error; busy <= 1.
  - Go to SETTLE if SETTLE_CYCLES>0, otherwise go to ISSUE.
  - If complete and error are both high, run_error=1.
  - complete and error are ignored outside IDLE and after done.
- SETTLE: count SETTLE_CYCLES edges, then go to ISSUE.
- ISSUE: drive mem_rd_en=1 and mem_addr=addr for exactly one cycle, then go to CAPTURE.
- CAPTURE: register mem_rdata into out_data and addr into out_addr. Set out_valid=1. Set out_last=(addr==RESULT_BASE+RESULT_WORDS-1). Go to SEND.
- SEND: hold out_valid, out_data, out_addr and out_last stable until out_valid&out_ready on a clk edge. On that handshake, out_valid <= 0, then:
  - if out_last: go to DONE;
  - otherwise: addr <= addr+1 and go to ISSUE.
- Data must never change while out_valid=1 and out_ready=0.
- out_ready may be held high permanently. Throughput is then 1 word per 3 cycles.
- DONE: busy=0, done=1. Remain in DONE until reset.
- Address arithmetic is ADDR_W-bit. RESULT_BASE+RESULT_WORDS-1 must be < 2**ADDR_W; there is no wrap-around.
- mem_rd_en=0 in every state except ISSUE. mem_addr holds its last value when not reading.
- Latency, trigger edge to first out_valid, with SETTLE_CYCLES=1: trigger edge, SETTLE edge, ISSUE edge, CAPTURE edge. out_valid is high after the 3rd edge following the trigger edge.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined:
  - Keep a running DATA_W-bit sum, modulo 2**DATA_W, of every accepted data beat. It is cleared at trigger.
  - After the last data word, emit one extra beat: out_addr=0, out_data=sum, out_last=1.
  - The final data word then has out_last=0.
  - done is set after the checksum beat handshakes.
- Undefined: no checksum logic or beat. out_last goes on the final data word.

Test Plan:
- Basic dump: RESULT_WORDS=4, mem[2048..2051]=5, -3, 0, 7; complete pulses; out_ready=1 -> four beats with out_addr 2048..2051 and data 0x00000005, 0xFFFFFFFD, 0, 7; out_last only on 2051; done=1; run_error=0; first out_valid 3 edges after the trigger edge.
- Backpressure: out_ready low for 5 cycles while word 2049 is valid -> out_data and out_addr stay stable, no extra mem_rd_en; dump completes with no loss or duplication.
- Error run: error=1 and complete=0 -> run_error=1 and the full dump still occurs; complete and error both high -> run_error=1.
- Reset mid-dump: reset=1 during SEND of word 2050 -> next edge: all outputs 0, state IDLE; a fresh trigger restarts from 2048.
- No retrigger: complete stays high after done, and a second pulse arrives -> no further mem_rd_en; done stays 1.
- DUMP_CHECKSUM_EN: data 5, -3, 0, 7 -> extra beat with out_data=9 and out_last=1; beat 2051 has out_last=0. A sum overflowing 32 bits wraps.
